// File: rtl/rv32i_types.sv
// Shared core types: decode/rename <-> RAT interface structs, register index widths,
// and the arch-to-phys map array used by both the RAT and the RRAT.
package rv32i_types;

  localparam int unsigned PHYS_REG_IDX  = 5;
  localparam int unsigned ARCH_REG_IDX  = 4;
  localparam int unsigned PHYS_TAG_W    = PHYS_REG_IDX + 1;
  localparam int unsigned NUM_ARCH_REGS = 2 ** (ARCH_REG_IDX + 1);

  typedef struct packed {
    logic [ARCH_REG_IDX:0] rd;
    logic [ARCH_REG_IDX:0] rs1;
    logic [ARCH_REG_IDX:0] rs2;
    logic [PHYS_REG_IDX:0] pd;
    logic                  write_en;
  } decode_rename_to_RAT_t;

  typedef struct packed {
    logic [PHYS_REG_IDX:0] ps1;
    logic [PHYS_REG_IDX:0] ps2;
    logic                  ps1_valid;
    logic                  ps2_valid;
  } RAT_to_decode_rename_t;

  typedef logic [NUM_ARCH_REGS-1:0][PHYS_REG_IDX:0] rat_map_t;

  function automatic rat_map_t identity_map();
    rat_map_t m;
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      m[i] = PHYS_TAG_W'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rat_read_port.sv
// One combinational RAT lookup: x0 reads as tag 0/ready, and a same-cycle CDB broadcast of the
// currently mapped tag is bypassed into the ready bit.
module rat_read_port
  import rv32i_types::*;
(
  input  logic [ARCH_REG_IDX:0]  rs_i,
  input  rat_map_t               map_i,
  input  logic [NUM_ARCH_REGS-1:0] rdy_i,
  input  logic                   cdb_valid_i,
  input  logic [PHYS_REG_IDX:0]  cdb_pd_i,
  input  logic [ARCH_REG_IDX:0]  cdb_rd_i,
  output logic [PHYS_REG_IDX:0]  ps_o,
  output logic                   ps_valid_o
);

  always_comb begin
    ps_o       = map_i[rs_i];
    ps_valid_o = rdy_i[rs_i] |
                 (cdb_valid_i && (cdb_rd_i == rs_i) && (cdb_pd_i == map_i[rs_i]));
    if (rs_i == '0) begin
      ps_o       = '0;
      ps_valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/rename_alias_table.sv
// Register alias table: zero-latency source lookup for rename, rd->pd recording at the edge,
// CDB wakeup of ready bits, and wholesale restore from the RRAT on flush.
module rename_alias_table
  import rv32i_types::*;
#(
  parameter int unsigned P_REG_IDX_NUM_BITS    = PHYS_REG_IDX,
  parameter int unsigned ARCH_REG_IDX_NUM_BITS = ARCH_REG_IDX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  decode_rename_to_RAT_t         decode_to_RAT,
  output RAT_to_decode_rename_t         rat_to_decode,
  input  logic                          cdb_valid,
  input  logic [P_REG_IDX_NUM_BITS:0]   cdb_pd,
  input  logic [ARCH_REG_IDX_NUM_BITS:0] cdb_rd,
  input  logic                          flush,
  input  rat_map_t                      rrat_map
);

  localparam int unsigned NumEntries = 2 ** (ARCH_REG_IDX_NUM_BITS + 1);

  rat_map_t              map_q, map_d;
  logic [NumEntries-1:0] rdy_q, rdy_d;

  // Priority per entry: flush, then rename, then CDB wakeup (rename applied last so it wins).
  always_comb begin
    map_d = map_q;
    rdy_d = rdy_q;
    if (flush) begin
      map_d    = rrat_map;
      map_d[0] = '0;
      rdy_d    = '1;
    end else begin
      if (cdb_valid && (cdb_rd != '0) && (map_q[cdb_rd] == cdb_pd)) begin
        rdy_d[cdb_rd] = 1'b1;
      end
      if (decode_to_RAT.write_en && (decode_to_RAT.rd != '0)) begin
        map_d[decode_to_RAT.rd] = decode_to_RAT.pd;
        rdy_d[decode_to_RAT.rd] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= identity_map();
      rdy_q <= '1;
    end else begin
      map_q <= map_d;
      rdy_q <= rdy_d;
    end
  end

  rat_read_port u_read_rs1 (
    .rs_i        (decode_to_RAT.rs1),
    .map_i       (map_q),
    .rdy_i       (rdy_q),
    .cdb_valid_i (cdb_valid),
    .cdb_pd_i    (cdb_pd),
    .cdb_rd_i    (cdb_rd),
    .ps_o        (rat_to_decode.ps1),
    .ps_valid_o  (rat_to_decode.ps1_valid)
  );

  rat_read_port u_read_rs2 (
    .rs_i        (decode_to_RAT.rs2),
    .map_i       (map_q),
    .rdy_i       (rdy_q),
    .cdb_valid_i (cdb_valid),
    .cdb_pd_i    (cdb_pd),
    .cdb_rd_i    (cdb_rd),
    .ps_o        (rat_to_decode.ps2),
    .ps_valid_o  (rat_to_decode.ps2_valid)
  );

endmodule

// File: tb/tb_rename_alias_table.sv
// Self-checking bench for rename_alias_table: directed literal checks plus randomized traffic
// compared every negedge against an array-based model of the alias table.
`timescale 1ns/100ps
module tb_rename_alias_table;
  import rv32i_types::*;

  logic                  clk = 1'b0;
  logic                  rst;
  decode_rename_to_RAT_t d2r;
  RAT_to_decode_rename_t r2d;
  logic                  cdb_valid;
  logic [PHYS_REG_IDX:0] cdb_pd;
  logic [ARCH_REG_IDX:0] cdb_rd;
  logic                  flush;
  rat_map_t              rrat;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_map [32];
  bit m_rdy [32];

  rename_alias_table dut (
    .clk           (clk),
    .rst           (rst),
    .decode_to_RAT (d2r),
    .rat_to_decode (r2d),
    .cdb_valid     (cdb_valid),
    .cdb_pd        (cdb_pd),
    .cdb_rd        (cdb_rd),
    .flush         (flush),
    .rrat_map      (rrat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_read(input int rs, output int ps, output bit v);
    if (rs == 0) begin
      ps = 0;
      v  = 1'b1;
    end else begin
      ps = m_map[rs];
      v  = m_rdy[rs] || (cdb_valid && int'(cdb_rd) == rs && int'(cdb_pd) == m_map[rs]);
    end
  endfunction

  // Model state update: flush restores, otherwise wakeup then rename (rename wins).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_map[i] = i;
        m_rdy[i] = 1'b1;
      end
    end else if (flush) begin
      for (int i = 0; i < 32; i++) begin
        m_map[i] = (i == 0) ? 0 : int'(rrat[i]);
        m_rdy[i] = 1'b1;
      end
    end else begin
      if (cdb_valid && cdb_rd != 0 && m_map[cdb_rd] == int'(cdb_pd)) m_rdy[cdb_rd] = 1'b1;
      if (d2r.write_en && d2r.rd != 0) begin
        m_map[d2r.rd] = int'(d2r.pd);
        m_rdy[d2r.rd] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int ps;
    bit v;
    if (chk_en) begin
      model_read(int'(d2r.rs1), ps, v);
      chk("model_ps1", int'(r2d.ps1), ps);
      chk("model_ps1_valid", int'(r2d.ps1_valid), int'(v));
      model_read(int'(d2r.rs2), ps, v);
      chk("model_ps2", int'(r2d.ps2), ps);
      chk("model_ps2_valid", int'(r2d.ps2_valid), int'(v));
    end
  end

  task automatic idle_inputs();
    d2r       = '0;
    cdb_valid = 1'b0;
    cdb_pd    = '0;
    cdb_rd    = '0;
    flush     = 1'b0;
  endtask

  // Advance one cycle; inputs change 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Literal checks land 1ns after the negedge, outputs fully settled.
  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic lit1(input string name, input int ps, input int v);
    chk({name, "_ps1"}, int'(r2d.ps1), ps);
    chk({name, "_v1"}, int'(r2d.ps1_valid), v);
  endtask

  task automatic lit2(input string name, input int ps, input int v);
    chk({name, "_ps2"}, int'(r2d.ps2), ps);
    chk({name, "_v2"}, int'(r2d.ps2_valid), v);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rrat = '0;
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset identity.
    d2r.rs1 = 5; d2r.rs2 = 7;
    at_sample(); lit1("reset", 5, 1); lit2("reset", 7, 1);

    // Rename 5->40, then CDB wakeup with same-cycle bypass.
    tick(); d2r.rd = 5; d2r.pd = 40; d2r.write_en = 1;
    at_sample(); lit1("pre_rename", 5, 1);
    tick(); d2r.write_en = 0;
    at_sample(); lit1("renamed", 40, 0);
    tick(); cdb_valid = 1; cdb_pd = 40; cdb_rd = 5;
    at_sample(); lit1("bypass", 40, 1);
    tick(); cdb_valid = 0;
    at_sample(); lit1("woken", 40, 1);

    // Stale tag ignored.
    tick(); d2r.pd = 41; d2r.write_en = 1;
    tick(); d2r.write_en = 0; cdb_valid = 1; cdb_pd = 40; cdb_rd = 5;
    at_sample(); lit1("stale_bypass", 41, 0);
    tick(); cdb_valid = 0;
    at_sample(); lit1("stale_after", 41, 0);

    // Rename beats CDB on the same entry.
    tick(); d2r.rs1 = 3; d2r.rd = 3; d2r.pd = 50; d2r.write_en = 1;
    cdb_valid = 1; cdb_pd = 3; cdb_rd = 3;
    tick(); d2r.write_en = 0; cdb_valid = 0;
    at_sample(); lit1("rename_wins", 50, 0);

    // x0 writes ignored; same-cycle read of own rd returns old mapping.
    tick(); d2r.rs1 = 0; d2r.rd = 0; d2r.pd = 33; d2r.write_en = 1;
    at_sample(); lit1("x0_same", 0, 1);
    tick(); d2r.write_en = 0;
    at_sample(); lit1("x0_after", 0, 1);
    tick(); d2r.rs2 = 9; d2r.rd = 9; d2r.pd = 44; d2r.write_en = 1;
    at_sample(); lit2("self_rd_old", 9, 1);
    tick(); d2r.write_en = 0;
    at_sample(); lit2("self_rd_new", 44, 0);

    // Flush while rename and CDB are active.
    tick(); d2r.rd = 12; d2r.pd = 61; d2r.write_en = 1;
    tick(); d2r.rd = 7; d2r.pd = 60;
    for (int i = 0; i < 32; i++) rrat[i] = (i == 0) ? '0 : PHYS_TAG_W'(i + 32);
    flush = 1; cdb_valid = 1; cdb_pd = 61; cdb_rd = 12;
    tick(); idle_inputs();
    for (int i = 0; i < 16; i++) begin
      d2r.rs1 = 5'(i); d2r.rs2 = 5'(i + 16);
      at_sample();
      lit1("flush_entry", (i == 0) ? 0 : i + 32, 1);
      lit2("flush_entry", i + 48, 1);
      tick();
    end

    // Async reset mid-cycle restores identity immediately.
    d2r.rs1 = 9; d2r.rd = 9; d2r.pd = 22; d2r.write_en = 1;
    tick(); d2r.write_en = 0;
    #1 rst = 1'b1;
    #1 lit1("async_rst", 9, 1);
    tick(); rst = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      d2r.rs1      = 5'($urandom_range(0, 31));
      d2r.rs2      = 5'($urandom_range(0, 31));
      d2r.rd       = 5'($urandom_range(0, 31));
      d2r.pd       = 6'($urandom_range(0, 63));
      d2r.write_en = ($urandom_range(0, 1) == 1);
      cdb_valid    = ($urandom_range(0, 1) == 1);
      cdb_rd       = ($urandom_range(0, 3) == 0) ? d2r.rs1 : 5'($urandom_range(0, 31));
      cdb_pd       = ($urandom_range(0, 3) != 0) ? 6'(m_map[cdb_rd]) : 6'($urandom_range(0, 63));
      flush        = ($urandom_range(0, 31) == 0);
      if (flush) begin
        for (int i = 0; i < 32; i++) rrat[i] = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_alias_table.md
Name: rename_alias_table

Overview:
- Register alias table (RAT) for the out-of-order core: the responder side of the decode/rename ↔ RAT request interface.
- Decode/rename sends rs1/rs2/rd plus the newly allocated pd. The RAT returns the current physical mappings and ready bits for the sources in the same cycle, then records rd→pd at the clock edge.
- CDB broadcasts mark mappings ready.
- On a pipeline flush, the table is restored wholesale from the retirement RAT (RRAT).

Parameters:
- P_REG_IDX_NUM_BITS, default PHYS_REG_IDX (5), MSB index of a physical register tag; tag width = P_REG_IDX_NUM_BITS+1.
- ARCH_REG_IDX_NUM_BITS, default ARCH_REG_IDX (4), MSB index of an architectural register index; 2^(ARCH_REG_IDX_NUM_BITS+1) = 32 entries.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- decode_to_RAT  in  decode_rename_to_RAT_t  fields: rd, rs1, rs2 (ARCH width), pd (PHYS width), write_en
- rat_to_decode  out  RAT_to_decode_rename_t  fields: ps1, ps2 (PHYS width), ps1_valid, ps2_valid
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_pd  in  PHYS width  physical tag being broadcast
- cdb_rd  in  ARCH width  architectural destination of the broadcast
- flush  in  1  mispredict/exception recovery from the ROB
- rrat_map  in  32 x PHYS width  committed mapping from the RRAT, entry i = arch reg i

Behaviour:
- State:
  - map[0..31]: physical tags.
  - rdy[0..31]: ready bits.
  - No other state; no FSM beyond the per-entry update priority below.
- Reset (async, rst=1):
  - map[i] = i and rdy[i] = 1 for all i.
  - Outputs follow combinationally: ps1 = map[rs1], etc.
- Read (combinational, zero latency):
  - ps1 = map[rs1]; ps1_valid = rdy[rs1].
  - CDB bypass: if cdb_valid and cdb_rd == rs1 and cdb_pd == map[rs1], then ps1_valid = 1 in the same cycle.
  - ps2 is identical using rs2.
  - Reads return the pre-edge mapping. An instruction whose rs equals its own rd therefore sees the old producer, not its own pd.
  - rs == 0 → ps = 0, valid = 1, regardless of table contents.
- Rename write:
  - Condition: write_en = 1 and rd != 0.
  - At posedge: map[rd] <= pd; rdy[rd] <= 0.
  - Writes with rd = 0 are ignored; map[0] stays 0 and rdy[0] stays 1 permanently.
- CDB wakeup:
  - Condition: cdb_valid and cdb_rd != 0 and map[cdb_rd] == cdb_pd.
  - At posedge: rdy[cdb_rd] <= 1.
  - A stale tag (map already renamed to a newer pd) is ignored.
- Per-entry update priority at each posedge, highest first:
  1. flush: map <= rrat_map; all rdy <= 1; map[0] forced to 0. Rename and CDB updates that cycle are dropped.
  2. Rename write to the entry: map/rdy take the new pd with rdy = 0, even if the CDB matches the old tag the same cycle.
  3. CDB wakeup.
- Flush read path:
  - Read outputs are not gated by flush.
  - Decode discards its output during flush; the RAT does not care.
- Reset mid-operation: async reset overrides everything immediately; state returns to the identity mapping with rdy all 1.
- No handshake or backpressure: write_en is the sole qualifier; stall gating is upstream.

Decomposition:
- Shared package rv32i_types holds:
  - decode_rename_to_RAT_t and RAT_to_decode_rename_t.
  - PHYS_REG_IDX and ARCH_REG_IDX.
  - A new packed array type rat_map_t (32 x PHYS tag) used by both the RAT and the RRAT.
- One small sub-module is natural: rat_read_port, the combinational lookup with x0 override and CDB bypass. It is instantiated twice (rs1, rs2).
- The table itself stays in rename_alias_table.

Test Plan:
- Reset → read rs1=5, rs2=7: ps1=5, ps2=7, both valid=1.
- Rename rd=5, pd=40, write_en=1; next cycle read rs1=5 → ps1=40, valid=0. Then CDB pd=40, rd=5 → same-cycle bypass valid=1; the cycle after, rdy[5]=1 without bypass.
- Rename rd=5 → pd=40, then rd=5 → pd=41. CDB pd=40, rd=5 → ps1 stays 41, valid=0 (stale tag ignored).
- Same cycle: rename rd=3 → pd=50 and CDB pd=map[3], rd=3 → next cycle map[3]=50, rdy=0 (rename wins).
- Rename rd=0, pd=33; read rs1=0 → ps1=0, valid=1. Also the same-cycle read of rs1=rd=9 while renaming 9 → 44 returns the old map[9].
- Rename several regs, then flush with rrat_map[i] = i+32 (entry 0 = 0) while write_en=1 and CDB active → all entries = rrat_map, all valid=1, no rename applied. Also assert rst mid-sequence → immediate identity map.
